// File: rtl/gene_pkg.sv
// rtl/gene_pkg.sv - shared widths, attractor kind encoding and packed result record
package gene_pkg;

  localparam int STATE_W = 8;
  localparam int CNT_W   = 9;

  typedef enum logic [1:0] {
    FIXED    = 2'b00,
    CYCLE    = 2'b01,
    UNRES    = 2'b10,
    CONFLICT = 2'b11
  } attr_kind_t;

  typedef struct packed {
    logic [STATE_W-1:0] init;
    logic [STATE_W-1:0] state;
    attr_kind_t         kind;
    logic [3:0]         period;
  } attr_rec_t;

  function automatic attr_kind_t classify(input logic fixed, input logic cycle);
    case ({fixed, cycle})
      2'b10:   return FIXED;
      2'b01:   return CYCLE;
      2'b11:   return CONFLICT;
      default: return UNRES;
    endcase
  endfunction

endpackage

// File: rtl/rec_fifo.sv
// rtl/rec_fifo.sv - first-word-fall-through FIFO of result records with synchronous flush
module rec_fifo
  import gene_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      push,
  input  attr_rec_t din,
  input  logic      pop,
  output attr_rec_t dout,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  attr_rec_t   mem_q [DEPTH];

  // Extra pointer bit distinguishes a wrapped (full) state from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full) wr_d = wr_q + PTR_ONE;
      if (pop && !empty) rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/attractor_recorder.sv
// rtl/attractor_recorder.sv - classifies sweep verdicts, buffers records, keeps per-kind tallies
// Optional distinct fixed-point counting is built when ATTR_REC_DISTINCT_EN is defined.
module attractor_recorder
  import gene_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int N_INIT = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sweep_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_init,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_fixed,
  input  logic               in_cycle,
  input  logic [3:0]         in_period,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [21:0]        out_data,
  output logic [CNT_W-1:0]   fixed_cnt,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   unres_cnt,
  output logic [CNT_W-1:0]   conflict_cnt,
  output logic [CNT_W-1:0]   distinct_cnt,
  output logic               done
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_INIT);

  logic             live_q;
  logic             done_q, done_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] tally_q [4];
  logic [CNT_W-1:0] tally_d [4];
  logic             accept, fifo_empty, fifo_full;
  attr_kind_t       kind;
  attr_rec_t        rec, head;

  assign kind       = classify(in_fixed, in_cycle);
  assign rec.init   = in_init;
  assign rec.state  = in_state;
  assign rec.kind   = kind;
  assign rec.period = (kind == CYCLE) ? in_period : 4'd0;

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready = live_q && !fifo_full && !done_q && !sweep_clr;
  assign accept   = in_valid && in_ready;

  rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (sweep_clr),
    .push  (accept),
    .din   (rec),
    .pop   (out_valid && out_ready),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head;

  always_comb begin
    tally_d = tally_q;
    acc_d   = acc_q;
    done_d  = done_q;
    if (sweep_clr) begin
      for (int k = 0; k < 4; k++) tally_d[k] = '0;
      acc_d  = '0;
      done_d = 1'b0;
    end else if (accept) begin
      if (tally_q[kind] != '1) tally_d[kind] = tally_q[kind] + CNT_ONE;
      acc_d = acc_q + CNT_ONE;
      if (acc_d == N_LAST) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q <= 1'b0;
      done_q <= 1'b0;
      acc_q  <= '0;
      for (int k = 0; k < 4; k++) tally_q[k] <= '0;
    end else begin
      live_q  <= 1'b1;
      done_q  <= done_d;
      acc_q   <= acc_d;
      tally_q <= tally_d;
    end
  end

  assign fixed_cnt    = tally_q[FIXED];
  assign cycle_cnt    = tally_q[CYCLE];
  assign unres_cnt    = tally_q[UNRES];
  assign conflict_cnt = tally_q[CONFLICT];
  assign done         = done_q;

`ifdef ATTR_REC_DISTINCT_EN
  logic [(1<<STATE_W)-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]        dist_q, dist_d;

  always_comb begin
    seen_d = seen_q;
    dist_d = dist_q;
    if (sweep_clr) begin
      seen_d = '0;
      dist_d = '0;
    end else if (accept && kind == FIXED && !seen_q[in_state]) begin
      seen_d[in_state] = 1'b1;
      if (dist_q != '1) dist_d = dist_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_q <= '0;
      dist_q <= '0;
    end else begin
      seen_q <= seen_d;
      dist_q <= dist_d;
    end
  end

  assign distinct_cnt = dist_q;
`else
  assign distinct_cnt = '0;
`endif

endmodule

// File: tb/tb_attractor_recorder.sv
// tb/tb_attractor_recorder.sv - randomized scoreboard bench for attractor_recorder
module tb_attractor_recorder;

  localparam int DEPTH  = 8;
  localparam int N_INIT = 256;

  logic       clk = 1'b0;
  logic       rst, sweep_clr, in_valid, in_ready;
  logic [7:0] in_init, in_state;
  logic       in_fixed, in_cycle;
  logic [3:0] in_period;
  logic       out_valid, out_ready;
  logic [21:0] out_data;
  logic [8:0] fixed_cnt, cycle_cnt, unres_cnt, conflict_cnt, distinct_cnt;
  logic       done;

  attractor_recorder #(.DEPTH(DEPTH), .N_INIT(N_INIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .sweep_clr    (sweep_clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_init      (in_init),
    .in_state     (in_state),
    .in_fixed     (in_fixed),
    .in_cycle     (in_cycle),
    .in_period    (in_period),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fixed_cnt    (fixed_cnt),
    .cycle_cnt    (cycle_cnt),
    .unres_cnt    (unres_cnt),
    .conflict_cnt (conflict_cnt),
    .distinct_cnt (distinct_cnt),
    .done         (done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [21:0] q[$];
  int          tally_m[4];
  int          acc_m = 0;
  int          dist_m = 0;
  bit          seen_m[256];
  bit          live_m = 0;
  bit          rnd_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int k = 0; k < 4; k++) tally_m[k] = 0;
    acc_m  = 0;
    dist_m = 0;
    for (int k = 0; k < 256; k++) seen_m[k] = 0;
  endtask

  // Scoreboard / reference model: evaluated mid-cycle, predicts what the next edge does.
  always @(negedge clk) begin
    logic [21:0] rec;
    logic [1:0]  kind;
    logic [3:0]  per;
    logic        exp_ready;
    if (!rst) begin
      model_clear();
      live_m = 0;
      chk("rst_out_data", 32'(out_data), 32'd0);
    end
    exp_ready = live_m && rst && (q.size() < DEPTH) && (acc_m < N_INIT) && !sweep_clr;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("done", 32'(done), 32'(acc_m >= N_INIT));
    chk("fixed_cnt", 32'(fixed_cnt), tally_m[0]);
    chk("cycle_cnt", 32'(cycle_cnt), tally_m[1]);
    chk("unres_cnt", 32'(unres_cnt), tally_m[2]);
    chk("conflict_cnt", 32'(conflict_cnt), tally_m[3]);
    chk("distinct_cnt", 32'(distinct_cnt), dist_m);
    if (q.size() != 0 && out_valid) chk("out_data", 32'(out_data), 32'(q[0]));
    if (rst) begin
      if (sweep_clr) model_clear();
      else begin
        if (out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          kind = in_fixed ? (in_cycle ? 2'd3 : 2'd0) : (in_cycle ? 2'd1 : 2'd2);
          per  = (kind == 2'd1) ? in_period : 4'd0;
          rec  = {in_init, in_state, kind, per};
          q.push_back(rec);
          tally_m[kind] = tally_m[kind] + 1;
          acc_m = acc_m + 1;
`ifdef ATTR_REC_DISTINCT_EN
          if (kind == 2'd0 && !seen_m[in_state]) begin
            seen_m[in_state] = 1;
            dist_m = dist_m + 1;
          end
`endif
        end
      end
      live_m = 1;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [7:0] i, input logic [7:0] s, input logic f,
                      input logic c, input logic [3:0] p);
    int n = 0;
    in_valid = 1'b1; in_init = i; in_state = s;
    in_fixed = f; in_cycle = c; in_period = p;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rnd_rdy = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    n_bad++;
    finish_run();
  end

  initial begin
    rst = 1'b0; sweep_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_init = '0; in_state = '0; in_fixed = 1'b0; in_cycle = 1'b0; in_period = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Fixed points, two sharing a state.
    out_ready = 1'b1;
    send(8'd0, 8'h00, 1'b1, 1'b0, 4'd0);
    send(8'd99, 8'h53, 1'b1, 1'b0, 4'd0);
    send(8'd255, 8'h53, 1'b1, 1'b0, 4'd0);
    drain();
    chk("fixed3", 32'(fixed_cnt), 32'd3);
`ifdef ATTR_REC_DISTINCT_EN
    chk("distinct2", 32'(distinct_cnt), 32'd2);
`else
    chk("distinct0", 32'(distinct_cnt), 32'd0);
`endif

    send(8'd56, 8'h1C, 1'b0, 1'b1, 4'd2);
    chk("cycle_rec", 32'(out_data), 32'h000E0712);
    chk("cycle_valid", 32'(out_valid), 32'd1);
    send(8'd7, 8'h44, 1'b1, 1'b1, 4'd5);
    send(8'd8, 8'h45, 1'b0, 1'b0, 4'd9);
    drain();

    // Fill to DEPTH with the consumer stalled, then one pop.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(8'(16 + i), 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    @(negedge clk);
    chk("full_ready", 32'(in_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("pop_ready", 32'(in_ready), 32'd1);
    drain();

    // Full sweep from a cleared state with a random consumer.
    @(posedge clk);
    #1 sweep_clr = 1'b1;
    @(posedge clk);
    #1 sweep_clr = 1'b0;
    rnd_rdy = 1;
    for (int i = 0; i < N_INIT; i++)
      send(8'(i), 8'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 4'($urandom));
    @(negedge clk);
    chk("sweep_done", 32'(done), 32'd1);
    chk("tally_sum", 32'(fixed_cnt) + 32'(cycle_cnt) + 32'(unres_cnt) + 32'(conflict_cnt),
        32'(N_INIT));
    @(posedge clk);
    #1 in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 sweep_clr = 1'b1;
    @(posedge clk);
    #1 sweep_clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_fixed", 32'(fixed_cnt), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a sweep.
    rnd_rdy = 0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(8'(i), 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    send(8'd200, 8'h21, 1'b0, 1'b1, 4'd7);
    drain();
    repeat (2) @(posedge clk);
    finish_run();
  end

endmodule

// File: doc/attractor_recorder.md
# attractor_recorder

Downstream sink of the gene-network sweep. For each initial state, the fixed-point and cycle checkers produce one verdict; this block accepts it and classifies the attractor. It buffers a packed result record in a FIFO behind a valid/ready output port and keeps per-sweep tallies. It asserts `done` once all 256 initial states have been recorded.

## Interface
Parameters:
- `DEPTH`, 8: result FIFO entries (power of two, ≥2).
- `N_INIT`, 256: verdicts per sweep.

Ports:
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `sweep_clr`  in  1: synchronous clear of tallies, FIFO and `done`.
- `in_valid`  in  1: verdict present.
- `in_ready`  out  1: verdict accepted when `in_valid && in_ready`.
- `in_init`  in  8: initial state of the trajectory.
- `in_state`  in  8: network state at the verdict.
- `in_fixed`  in  1: fixed-point flag.
- `in_cycle`  in  1: cycle flag.
- `in_period`  in  4: cycle length; ignored unless the kind is CYCLE.
- `out_valid`  out  1: record available.
- `out_ready`  in  1: consumer takes the record when `out_valid && out_ready`.
- `out_data`  out  22: packed record `{init[21:14], state[13:6], kind[5:4], period[3:0]}`.
- `fixed_cnt`, `cycle_cnt`, `unres_cnt`, `conflict_cnt`  out  9 each: tallies per kind.
- `distinct_cnt`  out  9: number of distinct fixed-point states.
- `done`  out  1: sticky; high once `N_INIT` verdicts have been accepted.

## Operation
- Kind encoding:
  - FIXED = 2'b00 (only `in_fixed` high).
  - CYCLE = 2'b01 (only `in_cycle` high).
  - UNRES = 2'b10 (neither flag high).
  - CONFLICT = 2'b11 (both flags high).
- The stored `period` is forced to 0 for every kind except CYCLE.
- `in_ready = !full && !done && !sweep_clr`.
- On accept, in one cycle:
  - push the record into the FIFO;
  - increment the tally for its kind;
  - increment the internal 9-bit `acc_cnt`.
- `done` sets on the cycle in which `acc_cnt` goes to `N_INIT`. While `done` is high, no further input is accepted. The FIFO keeps draining.
- FIFO behaviour:
  - first-word-fall-through;
  - push and pop in the same cycle are allowed when the FIFO is neither empty nor full;
  - `in_ready` deasserts when full, so no push is accepted while full (there is no full-bypass);
  - push and pop pointers wrap modulo `DEPTH`;
  - an extra pointer bit separates full from empty.
- Tallies saturate at 9'h1FF. This is unreachable under `N_INIT` = 256 and is kept as a guard.
- `sweep_clr` zeroes tallies, `acc_cnt`, `done`, FIFO pointers and the distinct bitmap, and drops `out_valid`. It has priority over a simultaneous accept or pop.
- Reset values: every counter is 0; `done`, `out_valid` and `in_ready` are 0 while `rst` is low. `in_ready` becomes 1 on the first cycle after `rst` is released. Asserting `rst` in the middle of a sweep discards all state.

## Timing
- Accept at edge N: the record is visible on `out_data` with `out_valid=1` after edge N if the FIFO was empty. Latency is 1 cycle.
- Tallies and `distinct_cnt` are registered and reflect an accept after the same edge.
- `done` rises after the edge that accepts the 256th verdict. `in_ready` is low from that cycle on.
- A pop at edge N presents the next entry after edge N; `out_valid` drops if the FIFO is now empty.
- `out_data` is held stable while `out_valid && !out_ready`.

## Configuration
- Macro: `ATTR_REC_DISTINCT_EN`.
- When defined, the block contains a 256-bit seen-bitmap indexed by `in_state`. On a FIXED accept whose bit is clear, it sets the bit and increments `distinct_cnt`.
- When not defined, there is no bitmap and `distinct_cnt` is tied to 0.

## Structure
- Package `gene_pkg` holds:
  - `STATE_W` = 8;
  - the kind enum `attr_kind_t` (FIXED, CYCLE, UNRES, CONFLICT);
  - the packed record typedef `attr_rec_t` (22 bits);
  - `CNT_W` = 9.
- Sub-module `rec_fifo`: a parameterized synchronous FWFT FIFO of `attr_rec_t`, using the same `rst` and `sweep_clr` flush. Classification, tallies and the bitmap live in the top module.

## Test plan
- Reset → all outputs 0. After `rst` is released, `in_ready=1` and `out_valid=0`.
- Accept `{init=0, state=0x00, fixed=1}` followed by `{init=99, state=0x53, fixed=1}` and `{init=255, state=0x53, fixed=1}` → records with kind 00. Final values: `fixed_cnt=3`; `distinct_cnt=2` with the macro defined, 0 without.
- Accept `{init=56, state=0x1C, cycle=1, period=2}` → `out_data={0x38, 0x1C, 2'b01, 4'd2}` one cycle later; `cycle_cnt=1`.
- Both flags set with period 5 → kind 11 and period 0, `conflict_cnt=1`. Neither flag set → kind 10, `unres_cnt=1`.
- `out_ready=0`; push 8 records (`DEPTH`=8) → `in_ready=0`. Then a single pop → `in_ready=1` and the records come out in order. Hold `out_ready` low on a filled FIFO for 5 cycles → `out_data` stays stable.
- Full sweep of 256 verdicts with random `out_ready` → `done` rises after the 256th accept and the tally sum is 256. Then `sweep_clr` together with `in_valid` → no accept and everything is cleared.
